pipe_stall_ctrl: RTL



---
 rtl/pipe_stall_ctrl_if.sv | 34 +++
 rtl/pipe_stall_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline stall interface between the CPU stages and the stall controller.
//
// Signals:
//   stallreq_id      ID load-use hazard request
//   stallreq_ex      EX multi-cycle operation not done
//   inst_sram_rdata  instruction SRAM read data (one-cycle latency)
//   br_e             raw branch-taken from ID
//   stall            stall bus, [0] PC .. [5] WB, 1 = stop
//   id_inst          instruction ID must decode
//   br_e_o           gated branch-taken sent to IF
//   hold             hold buffer is driving id_inst
//
// master: the CPU side (drives requests, consumes stall/id_inst/br_e_o)
// slave:  the stall controller
interface pipe_stall_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic [31:0] inst_sram_rdata;
  logic        br_e;
  logic [5:0]  stall;
  logic [31:0] id_inst;
  logic        br_e_o;
  logic        hold;

  modport master (
    output stallreq_id, stallreq_ex, inst_sram_rdata, br_e,
    input  stall, id_inst, br_e_o, hold
  );

  modport slave (
    input  stallreq_id, stallreq_ex, inst_sram_rdata, br_e,
    output stall, id_inst, br_e_o, hold
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller for the five-stage CPU.
// Merges the ID load-use and EX busy requests into the per-stage stall bus,
// holds the ID instruction while PC/IF are frozen against the synchronous
// instruction SRAM, gates ID branch redirects during stalls, and keeps a
// saturating stall counter plus a sticky EX-stall watchdog.
//
// Ports:
//   clk            system clock, rising edge
//   resetn         asynchronous active-low reset
//   pif            stall interface (slave side), see pipe_stall_ctrl_if
//   stall_cnt      saturating count of cycles with stall[2] = 1
//   stall_timeout  sticky flag, EX stalled EX_STALL_MAX consecutive cycles
//
// Hold-buffer FSM:
//   state | meaning
//   RUN   | id_inst comes straight from the SRAM read data
//   HOLD  | id_inst comes from inst_buf, captured in the first stalled cycle
module pipe_stall_ctrl #(
  parameter int CNT_W        = 16,
  parameter int EX_STALL_MAX = 64
) (
  input  logic             clk,
  input  logic             resetn,
  pipe_stall_ctrl_if.slave pif,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stall_timeout
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam int         EXW    = $clog2(EX_STALL_MAX + 1);
  localparam logic [EXW-1:0] EX_MAX = EXW'(EX_STALL_MAX);

  logic [0:0]     state;
  logic [31:0]    inst_buf;
  logic [5:0]     stall_w;
  logic           stall_id;
  logic [EXW-1:0] ex_run;
  logic [EXW-1:0] ex_run_nxt;

  // Stall encoding; EX busy wins and additionally freezes EX itself.
  always_comb begin
    stall_w = 6'b000000;
    if (resetn) begin
      if (pif.stallreq_ex)
        stall_w = 6'b001111;
      else if (pif.stallreq_id)
        stall_w = 6'b000111;
    end
  end

  assign stall_id    = stall_w[2];
  assign pif.stall   = stall_w;
  assign pif.hold    = (state == HOLD);
  assign pif.id_inst = (state == HOLD) ? inst_buf : pif.inst_sram_rdata;
  // A branch still waiting on its operands must not redirect PC.
  assign pif.br_e_o  = pif.br_e & ~stall_id;

  always_comb begin
    ex_run_nxt = '0;
    if (pif.stallreq_ex)
      ex_run_nxt = (ex_run == EX_MAX) ? ex_run : ex_run + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= RUN;
      inst_buf <= '0;
    end else begin
      case (state)
        RUN: begin
          // Only the first stalled cycle's instruction is captured; a stall
          // that changes source while held does not recapture.
          if (stall_id) begin
            inst_buf <= pif.inst_sram_rdata;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (!stall_id)
            state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (stall_id && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Timeout is set at the same edge where ex_run reaches the limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_run        <= '0;
      stall_timeout <= 1'b0;
    end else begin
      ex_run <= ex_run_nxt;
      if (ex_run_nxt == EX_MAX)
        stall_timeout <= 1'b1;
    end
  end

endmodule
